// File: rtl/execute_cycle.sv
// Execute stage: operand forwarding, ALU, branch resolution and the EX/MEM register.
module execute_cycle (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteE,
    input  logic        ALUSrcE,
    input  logic        MemWriteE,
    input  logic        ResultSrcE,
    input  logic        BranchE,
    input  logic [2:0]  ALUControlE,
    input  logic [31:0] RD1_E,
    input  logic [31:0] RD2_E,
    input  logic [31:0] Imm_Ext_E,
    input  logic [4:0]  RD_E,
    input  logic [31:0] PCE,
    input  logic [31:0] PCPlus4E,
    input  logic [31:0] ResultW,
    input  logic [1:0]  ForwardA_E,
    input  logic [1:0]  ForwardB_E,
    output logic        PCSrcE,
    output logic [31:0] PCTargetE,
    output logic        RegWriteM,
    output logic        MemWriteM,
    output logic        ResultSrcM,
    output logic [4:0]  RD_M,
    output logic [31:0] PCPlus4M,
    output logic [31:0] WriteDataM,
    output logic [31:0] ALU_ResultM
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned REGW = 5;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_SLT  = 3'b101;
    localparam logic [2:0] OP_SLTU = 3'b110;

    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            zero;

    // Forward mux for operand A; select 11 falls back to the register file.
    always_comb begin
        fwd_a = RD1_E;
        case (ForwardA_E)
            2'b01:   fwd_a = ResultW;
            2'b10:   fwd_a = ALU_ResultM;
            default: fwd_a = RD1_E;
        endcase
    end

    // Forward mux for operand B (also the store data).
    always_comb begin
        fwd_b = RD2_E;
        case (ForwardB_E)
            2'b01:   fwd_b = ResultW;
            2'b10:   fwd_b = ALU_ResultM;
            default: fwd_b = RD2_E;
        endcase
    end

    // ALU; the reserved opcode yields zero.
    always_comb begin
        src_b      = ALUSrcE ? Imm_Ext_E : fwd_b;
        alu_result = '0;
        case (ALUControlE)
            OP_ADD:  alu_result = fwd_a + src_b;
            OP_SUB:  alu_result = fwd_a - src_b;
            OP_AND:  alu_result = fwd_a & src_b;
            OP_OR:   alu_result = fwd_a | src_b;
            OP_XOR:  alu_result = fwd_a ^ src_b;
            OP_SLT:  alu_result = XLEN'($signed(fwd_a) < $signed(src_b));
            OP_SLTU: alu_result = XLEN'(fwd_a < src_b);
            default: alu_result = '0;
        endcase
    end

    // Branch resolution back to fetch (beq only).
    always_comb begin
        zero      = (alu_result == '0);
        PCSrcE    = BranchE & zero;
        PCTargetE = PCE + Imm_Ext_E;
    end

    // EX/MEM pipeline register with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            RegWriteM   <= 1'b0;
            MemWriteM   <= 1'b0;
            ResultSrcM  <= 1'b0;
            RD_M        <= REGW'(0);
            PCPlus4M    <= XLEN'(0);
            WriteDataM  <= XLEN'(0);
            ALU_ResultM <= XLEN'(0);
        end else begin
            RegWriteM   <= RegWriteE;
            MemWriteM   <= MemWriteE;
            ResultSrcM  <= ResultSrcE;
            RD_M        <= RD_E;
            PCPlus4M    <= PCPlus4E;
            WriteDataM  <= fwd_b;
            ALU_ResultM <= alu_result;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Directed, table-driven bench for the execute stage.
module tb_execute_cycle;

    logic        clk;
    logic        rst;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;

    int checks   = 0;
    int failures = 0;

    execute_cycle dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .PCPlus4M(PCPlus4M), .WriteDataM(WriteDataM),
        .ALU_ResultM(ALU_ResultM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst;
        logic        br;
        logic        asrc;
        logic [2:0]  op;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [31:0] pce;
        logic [31:0] resw;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        e_pcsrc;
        logic [31:0] e_tgt;
        logic [31:0] e_alu;
        logic [31:0] e_wd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic r, logic br, logic asrc, logic [2:0] op,
                                logic [31:0] rd1, logic [31:0] rd2, logic [31:0] imm,
                                logic [31:0] pce, logic [31:0] resw,
                                logic [1:0] fa, logic [1:0] fb,
                                logic e_pcsrc, logic [31:0] e_tgt,
                                logic [31:0] e_alu, logic [31:0] e_wd);
        vec_t v;
        v.name = name; v.rst = r; v.br = br; v.asrc = asrc; v.op = op;
        v.rd1 = rd1; v.rd2 = rd2; v.imm = imm; v.pce = pce; v.resw = resw;
        v.fa = fa; v.fb = fb; v.e_pcsrc = e_pcsrc; v.e_tgt = e_tgt;
        v.e_alu = e_alu; v.e_wd = e_wd;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one vector after the falling edge, check combinational outputs,
    // then check the EX/MEM register just after the rising edge.
    task automatic apply(vec_t v, int idx);
        logic        e_rw, e_mw, e_rs;
        logic [4:0]  e_rd;
        logic [31:0] e_p4;
        @(negedge clk);
        rst         = v.rst;
        BranchE     = v.br;
        ALUSrcE     = v.asrc;
        ALUControlE = v.op;
        RD1_E       = v.rd1;
        RD2_E       = v.rd2;
        Imm_Ext_E   = v.imm;
        PCE         = v.pce;
        ResultW     = v.resw;
        ForwardA_E  = v.fa;
        ForwardB_E  = v.fb;
        RegWriteE   = v.rst ? idx[0] : 1'b1;
        MemWriteE   = v.rst ? idx[1] : 1'b1;
        ResultSrcE  = v.rst ? idx[2] : 1'b1;
        RD_E        = 5'(idx + 1);
        PCPlus4E    = 32'h1000 + 32'(idx) * 4;
        e_rw = v.rst ? RegWriteE  : 1'b0;
        e_mw = v.rst ? MemWriteE  : 1'b0;
        e_rs = v.rst ? ResultSrcE : 1'b0;
        e_rd = v.rst ? RD_E       : 5'h00;
        e_p4 = v.rst ? PCPlus4E   : 32'h0;
        #1;
        check({v.name, ".PCSrcE"},    32'(PCSrcE), 32'(v.e_pcsrc));
        check({v.name, ".PCTargetE"}, PCTargetE,   v.e_tgt);
        @(posedge clk);
        #1;
        check({v.name, ".ALU_ResultM"}, ALU_ResultM,    v.e_alu);
        check({v.name, ".WriteDataM"},  WriteDataM,     v.e_wd);
        check({v.name, ".RegWriteM"},   32'(RegWriteM), 32'(e_rw));
        check({v.name, ".MemWriteM"},   32'(MemWriteM), 32'(e_mw));
        check({v.name, ".ResultSrcM"},  32'(ResultSrcM), 32'(e_rs));
        check({v.name, ".RD_M"},        32'(RD_M),      32'(e_rd));
        check({v.name, ".PCPlus4M"},    PCPlus4M,       e_p4);
    endtask

    localparam logic [31:0] NEG2 = 32'hFFFF_FFFE;

    initial begin
        rst = 1'b0; BranchE = 1'b0; ALUSrcE = 1'b0; ALUControlE = 3'b000;
        RD1_E = '0; RD2_E = '0; Imm_Ext_E = '0; PCE = '0; ResultW = '0;
        ForwardA_E = '0; ForwardB_E = '0; RegWriteE = 1'b0; MemWriteE = 1'b0;
        ResultSrcE = 1'b0; RD_E = '0; PCPlus4E = '0;

        //          name        rst br as op      rd1          rd2          imm           pce          resw         fa     fb     pcs tgt           alu           wd
        vecs.push_back(mk("rst0",   0, 0, 0, 3'b000, 32'h11,      32'h22,      32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h0,        32'h0));
        vecs.push_back(mk("rst1",   0, 0, 0, 3'b001, 32'h33,      32'h44,      32'h8,        32'h200,     32'h0,       2'b00, 2'b00, 0, 32'h208,      32'h0,        32'h0));
        vecs.push_back(mk("fwd10_postrst", 1, 0, 0, 3'b000, 32'h999, 32'h3,    32'h4,        32'h100,     32'h0,       2'b10, 2'b00, 0, 32'h104,      32'h3,        32'h3));
        vecs.push_back(mk("add",    1, 0, 0, 3'b000, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h1,        32'h3));
        vecs.push_back(mk("sub",    1, 0, 0, 3'b001, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'hFFFF_FFFB, 32'h3));
        vecs.push_back(mk("midrst", 0, 0, 0, 3'b010, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h0,        32'h0));
        vecs.push_back(mk("fwd10_midrst", 1, 0, 0, 3'b011, 32'h1234, 32'h3,    32'h4,        32'h100,     32'h0,       2'b10, 2'b00, 0, 32'h104,      32'h3,        32'h3));
        vecs.push_back(mk("and",    1, 0, 0, 3'b010, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h2,        32'h3));
        vecs.push_back(mk("or",     1, 0, 0, 3'b011, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'hFFFF_FFFF, 32'h3));
        vecs.push_back(mk("xor",    1, 0, 0, 3'b100, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'hFFFF_FFFD, 32'h3));
        vecs.push_back(mk("slt",    1, 0, 0, 3'b101, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h1,        32'h3));
        vecs.push_back(mk("sltu",   1, 0, 0, 3'b110, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h0,        32'h3));
        vecs.push_back(mk("rsvd",   1, 0, 0, 3'b111, NEG2,        32'h3,       32'h4,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h104,      32'h0,        32'h3));
        vecs.push_back(mk("imm",    1, 0, 1, 3'b000, 32'h20,      32'hAB,      32'hFFFF_FFF0, 32'h100,    32'h0,       2'b00, 2'b00, 0, 32'hF0,       32'h10,       32'hAB));
        vecs.push_back(mk("seed55", 1, 0, 0, 3'b000, 32'h50,      32'h5,       32'h0,        32'h100,     32'h0,       2'b00, 2'b00, 0, 32'h100,      32'h55,       32'h5));
        vecs.push_back(mk("fa10",   1, 0, 0, 3'b000, 32'h0,       32'h1,       32'h0,        32'h100,     32'h0,       2'b10, 2'b00, 0, 32'h100,      32'h56,       32'h1));
        vecs.push_back(mk("fa01",   1, 0, 0, 3'b000, 32'h0,       32'h1,       32'h0,        32'h100,     32'h100,     2'b01, 2'b00, 0, 32'h100,      32'h101,      32'h1));
        vecs.push_back(mk("fa11",   1, 0, 0, 3'b000, 32'h30,      32'h1,       32'h0,        32'h100,     32'h500,     2'b11, 2'b00, 0, 32'h100,      32'h31,       32'h1));
        vecs.push_back(mk("fab10",  1, 0, 0, 3'b000, 32'h7,       32'h9,       32'h0,        32'h100,     32'h500,     2'b10, 2'b10, 0, 32'h100,      32'h62,       32'h31));
        vecs.push_back(mk("fb01imm",1, 0, 1, 3'b000, 32'h2,       32'h9,       32'h8,        32'h100,     32'h77,      2'b00, 2'b01, 0, 32'h108,      32'hA,        32'h77));
        vecs.push_back(mk("beq_t",  1, 1, 0, 3'b001, 32'h7,       32'h7,       32'hFFFF_FFF8, 32'h40,     32'h0,       2'b00, 2'b00, 1, 32'h38,       32'h0,        32'h7));
        vecs.push_back(mk("beq_nt", 1, 1, 0, 3'b001, 32'h7,       32'h8,       32'hFFFF_FFF8, 32'h40,     32'h0,       2'b00, 2'b00, 0, 32'h38,       32'hFFFF_FFFF, 32'h8));

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Back-to-back forward-10 chain: each cycle adds 1 to the previous registered result.
        apply(mk("chain0", 1, 0, 1, 3'b000, 32'h0, 32'h4, 32'h1, 32'h0, 32'h0, 2'b10, 2'b00, 0, 32'h1, 32'h0, 32'h4), 30);
        apply(mk("chain1", 1, 0, 1, 3'b000, 32'h0, 32'h4, 32'h1, 32'h0, 32'h0, 2'b10, 2'b00, 0, 32'h1, 32'h1, 32'h4), 31);
        apply(mk("chain2", 1, 0, 1, 3'b000, 32'h0, 32'h4, 32'h1, 32'h0, 32'h0, 2'b10, 2'b10, 0, 32'h1, 32'h2, 32'h1), 32);

        // Branch while held in reset still resolves combinationally; M stays cleared.
        apply(mk("rst_br", 0, 1, 0, 3'b001, 32'h5, 32'h5, 32'h10, 32'h20, 32'h0, 2'b00, 2'b00, 1, 32'h30, 32'h0, 32'h0), 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
